// File: rtl/sync_filter_bank.sv
// Multi-channel synchronizer with per-channel stability filter.
// Produces clean levels plus registered rise/fall/glitch pulses.
`timescale 1ns/1ps

module sync_filter_bank #(
  parameter int              WIDTH   = 4,
  parameter int              STAGES  = 2,
  parameter int              FILT    = 0,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] glitch,
  output logic             any_change
);

  localparam int CW = (FILT > 0) ? $clog2(FILT + 1) : 1;
  localparam logic [CW-1:0] FILT_C = CW'(FILT);

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("sync_filter_bank: STAGES must be at least 2");
    end
    if (FILT < 0 || FILT > 65535) begin : g_bad_filt
      $error("sync_filter_bank: FILT must be within 0..65535");
    end
  endgenerate

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] ss;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_nxt  [WIDTH];
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;
  logic [WIDTH-1:0] glitch_nxt;

  assign ss = sync_q[STAGES-1];

  // cnt counts how many edges the synced level has disagreed with q
  always_comb begin
    q_nxt      = q;
    rise_nxt   = '0;
    fall_nxt   = '0;
    glitch_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt[i];
      if (ss[i] == q[i]) begin
        if (cnt[i] != '0) begin
          cnt_nxt[i]    = '0;
          glitch_nxt[i] = 1'b1;
        end
      end else if (cnt[i] == FILT_C) begin
        q_nxt[i]    = ss[i];
        cnt_nxt[i]  = '0;
        rise_nxt[i] = ss[i];
        fall_nxt[i] = ~ss[i];
      end else begin
        cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= RST_VAL;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      q          <= RST_VAL;
      rise       <= '0;
      fall       <= '0;
      glitch     <= '0;
      any_change <= 1'b0;
    end else begin
      sync_q[0] <= d;
      for (int k = 1; k < STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      q          <= q_nxt;
      rise       <= rise_nxt;
      fall       <= fall_nxt;
      glitch     <= glitch_nxt;
      any_change <= |(rise_nxt | fall_nxt);
    end
  end

endmodule

// File: tb/tb_sync_filter_bank.sv
// Bench for sync_filter_bank: three configurations checked every cycle
// against a history-based model, plus directed literal expectations.
`timescale 1ns/1ps

module tb_sync_filter_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d_a, d_b, d_c;
  logic [3:0] q_a, rise_a, fall_a, glitch_a;
  logic [3:0] q_b, rise_b, fall_b, glitch_b;
  logic [3:0] q_c, rise_c, fall_c, glitch_c;
  logic       any_a, any_b, any_c;

  int numChecks = 0;
  int numFails  = 0;

  // model state per instance: d history, ss history since reset, expected outputs
  logic [3:0] dh [3][8];
  logic [3:0] sh [3][8];
  int         nss [3];
  logic [3:0] mq [3];
  logic [3:0] mr [3];
  logic [3:0] mf [3];
  logic [3:0] mg [3];
  logic       ma [3];
  bit         modelValid = 1'b0;
  logic [3:0] cPulses = 4'h0;

  always #5 clk = ~clk;

  sync_filter_bank #(.WIDTH(4), .STAGES(2), .FILT(3), .RST_VAL(4'h0)) dut_a (
    .clk(clk), .rst(rst), .d(d_a), .q(q_a), .rise(rise_a), .fall(fall_a),
    .glitch(glitch_a), .any_change(any_a));

  sync_filter_bank #(.WIDTH(4), .STAGES(3), .FILT(0), .RST_VAL(4'h0)) dut_b (
    .clk(clk), .rst(rst), .d(d_b), .q(q_b), .rise(rise_b), .fall(fall_b),
    .glitch(glitch_b), .any_change(any_b));

  sync_filter_bank #(.WIDTH(4), .STAGES(2), .FILT(3), .RST_VAL(4'hA)) dut_c (
    .clk(clk), .rst(rst), .d(d_c), .q(q_c), .rise(rise_c), .fall(fall_c),
    .glitch(glitch_c), .any_change(any_c));

  function automatic int stgOf(input int m);
    return (m == 1) ? 3 : 2;
  endfunction

  function automatic int fltOf(input int m);
    return (m == 1) ? 0 : 3;
  endfunction

  function automatic logic [3:0] rvOf(input int m);
    return (m == 2) ? 4'hA : 4'h0;
  endfunction

  // A level is accepted once it has been seen FILT+1 edges in a row against q;
  // a disagreement that was pending on the previous edge and is gone now is a glitch.
  task automatic modelStep(input int m, input logic [3:0] dv, input logic r);
    logic [3:0] ssv, nq, nr, nf, ng;
    bit run;
    if (r) begin
      for (int k = 0; k < 8; k++) begin
        dh[m][k] = rvOf(m);
        sh[m][k] = rvOf(m);
      end
      nss[m] = 0;
      mq[m] = rvOf(m);
      mr[m] = 4'h0;
      mf[m] = 4'h0;
      mg[m] = 4'h0;
      ma[m] = 1'b0;
      modelValid = 1'b1;
    end else begin
      ssv = dh[m][stgOf(m)-1];
      nq = mq[m];
      nr = 4'h0;
      nf = 4'h0;
      ng = 4'h0;
      for (int ch = 0; ch < 4; ch++) begin
        if (ssv[ch] != mq[m][ch]) begin
          run = (nss[m] >= fltOf(m));
          for (int k = 0; k < fltOf(m); k++)
            if (sh[m][k][ch] == mq[m][ch]) run = 1'b0;
          if (run) begin
            nq[ch] = ssv[ch];
            nr[ch] = ssv[ch];
            nf[ch] = ~ssv[ch];
          end
        end else if (nss[m] > 0 && sh[m][0][ch] != mq[m][ch]) begin
          ng[ch] = 1'b1;
        end
      end
      for (int k = 7; k > 0; k--) begin
        sh[m][k] = sh[m][k-1];
        dh[m][k] = dh[m][k-1];
      end
      sh[m][0] = ssv;
      dh[m][0] = dv;
      if (nss[m] < 8) nss[m] = nss[m] + 1;
      mq[m] = nq;
      mr[m] = nr;
      mf[m] = nf;
      mg[m] = ng;
      ma[m] = |(nr | nf);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("a_q", q_a, mq[0]);
    checkOutput("a_rise", rise_a, mr[0]);
    checkOutput("a_fall", fall_a, mf[0]);
    checkOutput("a_glitch", glitch_a, mg[0]);
    checkOutput("a_any", {3'b0, any_a}, {3'b0, ma[0]});
    checkOutput("b_q", q_b, mq[1]);
    checkOutput("b_rise", rise_b, mr[1]);
    checkOutput("b_fall", fall_b, mf[1]);
    checkOutput("b_glitch", glitch_b, mg[1]);
    checkOutput("b_any", {3'b0, any_b}, {3'b0, ma[1]});
    checkOutput("c_q", q_c, mq[2]);
    checkOutput("c_rise", rise_c, mr[2]);
    checkOutput("c_fall", fall_c, mf[2]);
    checkOutput("c_glitch", glitch_c, mg[2]);
    checkOutput("c_any", {3'b0, any_c}, {3'b0, ma[2]});
    cPulses = cPulses | rise_c | fall_c | glitch_c | {3'b0, any_c};
  endtask

  always @(posedge clk) begin
    modelStep(0, d_a, rst);
    modelStep(1, d_b, rst);
    modelStep(2, d_c, rst);
  end

  always @(negedge clk) begin
    if (modelValid) compareAll();
  end

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                               input logic r, input int cycles);
    d_a = a;
    d_b = b;
    d_c = c;
    rst = r;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int gCnt, rCnt, fCnt, qCnt, hitCnt, rIdx, fIdx;
    logic [3:0] ra, rb, rc;

    // reset with all inputs high on instance a, then latency after release
    applyStimulus(4'hF, 4'h0, 4'hA, 1'b1, 2);
    applyStimulus(4'hF, 4'h0, 4'hA, 1'b0, 0);
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      checkOutput("lat_fall", fall_a, 4'h0);
      checkOutput("lat_glitch", glitch_a, 4'h0);
      if (e < 6) begin
        checkOutput("lat_q_hold", q_a, 4'h0);
        checkOutput("lat_rise_hold", rise_a, 4'h0);
      end else if (e == 6) begin
        checkOutput("lat_q_accept", q_a, 4'hF);
        checkOutput("lat_rise", rise_a, 4'hF);
        checkOutput("lat_any", {3'b0, any_a}, 4'h1);
      end else begin
        checkOutput("lat_rise_once", rise_a, 4'h0);
        checkOutput("lat_any_once", {3'b0, any_a}, 4'h0);
      end
    end

    // short excursion of FILT cycles is rejected with one glitch pulse
    applyStimulus(4'h0, 4'h0, 4'hA, 1'b0, 12);
    checkOutput("steady_q0", q_a, 4'h0);
    applyStimulus(4'h1, 4'h0, 4'hA, 1'b0, 3);
    applyStimulus(4'h0, 4'h0, 4'hA, 1'b0, 0);
    gCnt = 0; rCnt = 0; qCnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      gCnt += glitch_a[0];
      rCnt += rise_a[0];
      qCnt += q_a[0];
    end
    checkOutput("rej_glitch_count", 4'(gCnt), 4'd1);
    checkOutput("rej_rise_count", 4'(rCnt), 4'd0);
    checkOutput("rej_q_high", 4'(qCnt), 4'd0);

    // excursion of FILT+1 cycles is accepted
    applyStimulus(4'h1, 4'h0, 4'hA, 1'b0, 4);
    applyStimulus(4'h0, 4'h0, 4'hA, 1'b0, 0);
    gCnt = 0; rCnt = 0; qCnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      gCnt += glitch_a[0];
      rCnt += rise_a[0];
      qCnt += q_a[0];
    end
    checkOutput("acc_glitch_count", 4'(gCnt), 4'd0);
    checkOutput("acc_rise_count", 4'(rCnt), 4'd1);
    checkOutput("acc_q_seen", 4'(qCnt > 0), 4'd1);

    // simultaneous rise and fall on different channels
    applyStimulus(4'b0100, 4'h0, 4'hA, 1'b0, 12);
    checkOutput("sim_pre_q", q_a, 4'b0100);
    applyStimulus(4'b0010, 4'h0, 4'hA, 1'b0, 0);
    hitCnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rise_a == 4'b0010 && fall_a == 4'b0100 && any_a) hitCnt++;
    end
    checkOutput("sim_hits", 4'(hitCnt), 4'd1);
    checkOutput("sim_post_q", q_a, 4'b0010);

    // bypass configuration latency and pulse propagation
    applyStimulus(4'b0010, 4'b0100, 4'hA, 1'b0, 3);
    checkOutput("byp_q_before", {3'b0, q_b[2]}, 4'h0);
    @(negedge clk);
    checkOutput("byp_q_after", {3'b0, q_b[2]}, 4'h1);
    checkOutput("byp_rise", rise_b, 4'b0100);
    applyStimulus(4'b0010, 4'b0000, 4'hA, 1'b0, 8);
    applyStimulus(4'b0010, 4'b0100, 4'hA, 1'b0, 1);
    applyStimulus(4'b0010, 4'b0000, 4'hA, 1'b0, 0);
    qCnt = 0; rCnt = 0; fCnt = 0; gCnt = 0; rIdx = -1; fIdx = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      qCnt += q_b[2];
      gCnt += (glitch_b != 4'h0);
      if (rise_b[2]) begin rCnt++; rIdx = i; end
      if (fall_b[2]) begin fCnt++; fIdx = i; end
    end
    checkOutput("byp_q_width", 4'(qCnt), 4'd1);
    checkOutput("byp_rise_count", 4'(rCnt), 4'd1);
    checkOutput("byp_fall_count", 4'(fCnt), 4'd1);
    checkOutput("byp_rise_fall_gap", 4'(fIdx - rIdx), 4'd1);
    checkOutput("byp_glitch", 4'(gCnt), 4'd0);

    // reset while channel 3 has a pending change at count 2
    applyStimulus(4'b1010, 4'h0, 4'hA, 1'b0, 4);
    applyStimulus(4'b1010, 4'h0, 4'hA, 1'b1, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("mid_rst_q", q_a, 4'h0);
      checkOutput("mid_rst_rise", rise_a, 4'h0);
      checkOutput("mid_rst_glitch", glitch_a, 4'h0);
    end
    applyStimulus(4'b1010, 4'h0, 4'hA, 1'b0, 0);
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      checkOutput("mid_rel_glitch", glitch_a, 4'h0);
      if (e < 6) checkOutput("mid_rel_q", q_a, 4'h0);
      else begin
        checkOutput("mid_rel_q_acc", q_a, 4'b1010);
        checkOutput("mid_rel_rise", rise_a, 4'b1010);
      end
    end

    // non-zero reset value held at its own level never pulses
    checkOutput("rv_q", q_c, 4'hA);
    checkOutput("rv_pulses", cPulses, 4'h0);

    // randomized run: bits toggle with varied hold lengths, occasional reset
    ra = d_a; rb = d_b; rc = d_c;
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if ($urandom_range(0, 3) == 0) ra[ch] = ~ra[ch];
        if ($urandom_range(0, 3) == 0) rb[ch] = ~rb[ch];
        if ($urandom_range(0, 3) == 0) rc[ch] = ~rc[ch];
      end
      applyStimulus(ra, rb, rc, ($urandom_range(0, 149) == 0), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
